// File: rtl/dmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : dmem_loader
// Description : Collects a byte stream and writes it into data memory as
//               big-endian 32-bit words, starting at a captured base address
//               for a captured number of words. Supports abort and an
//               immediate completion for zero-length loads.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_we;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [1:0]          r_bytes;
    logic [DATA_W-1:0]   r_shift;

    // Abort must win over a handshake or a write in the same cycle, so the
    // registered strobes are masked by it combinationally.
    assign in_ready = r_ready & ~abort;
    assign mem_we   = r_we & ~abort;
    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_a    = r_addr;
    assign mem_wd   = r_shift;

    // Load sequencer: state, counters, word assembly and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_bytes <= '0;
            r_shift <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (word_cnt != '0) begin
                            r_cnt   <= word_cnt;
                            r_addr  <= base_addr;
                            r_idx   <= '0;
                            r_bytes <= '0;
                            r_shift <= '0;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_COLLECT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        // First byte ends up in the top lane after four shifts.
                        r_shift <= {r_shift[DATA_W-9:0], in_data};
                        if (r_bytes == 2'd3) begin
                            r_bytes <= '0;
                            r_ready <= 1'b0;
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end else begin
                            r_bytes <= r_bytes + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx  <= r_idx + c_one;
                        r_addr <= r_addr + c_one;   // wraps modulo 2^ADDR_W
                        if (r_idx == r_cnt - c_one) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= S_COLLECT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_loader
// Description : Scoreboard bench for dmem_loader. Stimulus pushes expected
//               memory writes and done pulses; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_cnt;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        busy;
    logic        done;

    dmem_loader #(.DATA_W(32), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [15:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          fails  = 0;
    int          n_writes = 0;
    logic [31:0] mem [logic [15:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0; e.a = a; e.d = d;
        q.push_back(e);
    endtask

    task automatic push_d();
        exp_t e;
        e.is_done = 1'b1; e.a = '0; e.d = '0;
        q.push_back(e);
    endtask

    // Memory model: a write lands on the rising edge while mem_we is high.
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] = mem_wd;
    end

    // Monitor: every write or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                exp_t e;
                n_writes++;
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL write: unexpected write a=%h d=%h, nothing expected", mem_a, mem_wd);
                end else begin
                    e = q.pop_front();
                    if (e.is_done || mem_a !== e.a || mem_wd !== e.d) begin
                        fails++;
                        $display("FAIL write: got a=%h d=%h, expected done=%0d a=%h d=%h",
                                 mem_a, mem_wd, e.is_done, e.a, e.d);
                    end
                end
            end
            if (done) begin
                exp_t e;
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL done: unexpected done pulse, nothing expected");
                end else begin
                    e = q.pop_front();
                    if (!e.is_done) begin
                        fails++;
                        $display("FAIL done: got done pulse, expected write a=%h d=%h", e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] b, input logic [15:0] c);
        start = 1'b1; base_addr = b; word_cnt = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte until it is accepted; optional random stalls on in_valid.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit sent = 1'b0;
        int guard = 0;
        while (!sent) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = b;
            @(negedge clk);
            if (in_valid && in_ready) sent = 1'b1;
            @(posedge clk); #1;
            guard++;
            if (!sent && guard > 200) begin
                checks++; fails++;
                $display("FAIL byte_timeout: byte %h not accepted, got in_ready=%b, expected 1", b, in_ready);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], stall);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (q.size() != 0 && guard < 60) begin
            @(posedge clk); guard++;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending events, expected 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
        abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we",   32'(mem_we),   0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_done",     32'(done),     0);
        chk("rst_mem_a",    32'(mem_a),    0);
        chk("rst_mem_wd",   mem_wd,        0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word load from address 0
        push_w(16'h0000, 32'h214a0015);
        push_w(16'h0001, 32'h0013000a);
        push_d();
        do_start(16'h0000, 16'd2);
        @(negedge clk);
        chk("busy_collect", 32'(busy), 1);
        chk("in_ready_collect", 32'(in_ready), 1);
        @(posedge clk); #1;
        send_word(32'h214a0015, 1'b0);
        send_word(32'h0013000a, 1'b0);
        wait_drain();
        chk("mem0", mem[16'h0000], 32'h214a0015);
        chk("mem1", mem[16'h0001], 32'h0013000a);

        // Three-word load, no stalls then random stalls: identical writes
        for (int pass = 0; pass < 2; pass++) begin
            w0 = n_writes;
            push_w(16'h0100, 32'h11223344);
            push_w(16'h0101, 32'ha55a0ff0);
            push_w(16'h0102, 32'hdeadbeef);
            push_d();
            do_start(16'h0100, 16'd3);
            send_word(32'h11223344, pass == 1);
            send_word(32'ha55a0ff0, pass == 1);
            send_word(32'hdeadbeef, pass == 1);
            wait_drain();
            chk("three_word_count", 32'(n_writes - w0), 3);
        end

        // Address wrap at the top of the word-address space
        push_w(16'hffff, 32'h01020304);
        push_w(16'h0000, 32'h8000007f);
        push_d();
        do_start(16'hffff, 16'd2);
        send_word(32'h01020304, 1'b0);
        send_word(32'h8000007f, 1'b0);
        wait_drain();

        // Zero-length load: done on the very next cycle, nothing else
        push_d();
        do_start(16'h1234, 16'd0);
        @(negedge clk);
        chk("zero_done", 32'(done), 1);
        chk("zero_in_ready", 32'(in_ready), 0);
        chk("zero_mem_we", 32'(mem_we), 0);
        chk("zero_busy", 32'(busy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_done_one_cycle", 32'(done), 0);
        chk("zero_in_ready_after", 32'(in_ready), 0);
        wait_drain();

        // Abort after two bytes of the second word
        push_w(16'h0200, 32'hcafebabe);
        do_start(16'h0200, 16'd2);
        send_word(32'hcafebabe, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h56;
        @(negedge clk);
        chk("abort_in_ready_masked", 32'(in_ready), 0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        wait_drain();
        chk("abort_no_word1", 32'(mem.exists(16'h0201)), 0);
        push_w(16'h0300, 32'h55667788);
        push_d();
        do_start(16'h0300, 16'd1);
        send_word(32'h55667788, 1'b0);
        wait_drain();

        // Asynchronous reset in the middle of a WRITE cycle
        push_w(16'h0400, 32'h0badf00d);
        do_start(16'h0400, 16'd2);
        send_word(32'h0badf00d, 1'b0);
        send_word(32'h99999999, 1'b0);
        chk("pre_rst_mem_we", 32'(mem_we), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_we", 32'(mem_we), 0);
        chk("arst_busy",   32'(busy),   0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_mem_a",  32'(mem_a),  0);
        chk("arst_mem_wd", mem_wd,      0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        chk("arst_no_write", 32'(mem.exists(16'h0401)), 0);
        chk("arst_word0_kept", mem[16'h0400], 32'h0badf00d);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_loader.md
DMEM_LOADER -- requirements
Module: dmem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits (fixed at 32 for 4-byte packing).
REQ-002 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle load request, sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, captured on accepted start.
REQ-007 SHALL have port word_cnt  input  ADDR_W  number of words to load, captured on accepted start.
REQ-008 SHALL have port abort  input  1  cancel the current load.
REQ-009 SHALL have port in_valid  input  1  byte-stream valid.
REQ-010 SHALL have port in_data  input  8  byte-stream data.
REQ-011 SHALL have port in_ready  output  1  byte-stream ready.
REQ-012 SHALL have port mem_a  output  ADDR_W  data-memory word address.
REQ-013 SHALL have port mem_wd  output  DATA_W  data-memory write data.
REQ-014 SHALL have port mem_we  output  1  data-memory write enable; memory writes on the rising edge while high.
REQ-015 SHALL have port busy  output  1  high in COLLECT or WRITE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-018 SHALL, in IDLE with start=1 and word_cnt!=0, capture base_addr and word_cnt, clear byte and word counters, and enter COLLECT.
REQ-019 SHALL, in IDLE with start=1 and word_cnt=0, enter DONE directly without writing memory.
REQ-020 SHALL drive in_ready=1 only in COLLECT; a byte transfers in any cycle with in_valid=1 and in_ready=1.
REQ-021 SHALL pack bytes big-endian: 1st byte -> bits 31:24, 2nd -> 23:16, 3rd -> 15:8, 4th -> 7:0.
REQ-022 SHALL enter WRITE on the cycle after the 4th byte transfers; mem_we=1 for exactly that one WRITE cycle.
REQ-023 SHALL drive mem_a = (captured base + word index) mod 2^ADDR_W, wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL hold mem_a and mem_wd stable throughout WRITE.
REQ-025 SHALL, leaving WRITE, increment word index and go to DONE if it was the last word, else COLLECT.
REQ-026 SHALL allow the next byte to transfer no earlier than the cycle after WRITE (max 4 bytes per 5 cycles).
REQ-027 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL ignore start when not in IDLE.
REQ-029 SHALL, on abort=1 in COLLECT or WRITE, return to IDLE next cycle with no write and no done pulse; a partial word is discarded; abort takes priority over a same-cycle byte transfer or write.
REQ-030 SHALL ignore abort in IDLE and DONE.
REQ-031 SHALL keep mem_we=0 in every state except WRITE.

Reset
REQ-032 SHALL, while rst=1, force IDLE and drive in_ready=0, mem_we=0, busy=0, done=0, mem_a=0, mem_wd=0, and clear all counters.
REQ-033 SHALL, on rst asserted mid-load, discard the load with no further memory write; previously written words are unaffected.

Verification
REQ-034 SHALL verify: start, base_addr=0x0000, word_cnt=2, bytes 21 4a 00 15 00 13 00 0a -> writes mem[0]=0x214a0015, mem[1]=0x0013000a, one done pulse after the 2nd write.
REQ-035 SHALL verify: in_valid toggled randomly during a 3-word load -> exactly 3 mem_we pulses, words identical to zero-stall case.
REQ-036 SHALL verify: base_addr=0xFFFF, word_cnt=2 -> writes at mem_a=0xFFFF then 0x0000.
REQ-037 SHALL verify: start with word_cnt=0 -> done one cycle after start, mem_we never high, in_ready never high.
REQ-038 SHALL verify: abort after 2 bytes of word 1 in a 2-word load -> IDLE next cycle, only word 0 written, no done; following start loads correctly.
REQ-039 SHALL verify: rst asserted asynchronously between clock edges during WRITE -> outputs reach reset values immediately, no write on following edge.
